// File: rtl/rf_wr_port_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package rf_wr_port_arbiter_pkg;

   localparam int RF_LL_FIFO_DEPTH = 2;
   localparam int RF_STARVE_LIMIT  = 8;

   // 'reg' is a keyword, so the write address field is named wreg
   typedef struct packed {
      logic        en;
      logic [4:0]  wreg;
      logic [31:0] data;
   } rf_wr_req_t;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ll_entry_t;

   function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
      return 32'(1) << rd;
   endfunction

endpackage

// File: rtl/rf_ll_fifo.sv
// Circular DEPTH-entry FIFO for long-latency results; exposes per-slot valid bits
// and slot contents so the owner can build a pending-destination mask.
module rf_ll_fifo
   import rf_wr_port_arbiter_pkg::*;
#(
   parameter int DEPTH = RF_LL_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  ll_entry_t              din,
   output ll_entry_t              head,
   output logic                   full,
   output logic                   empty,
   output logic      [DEPTH-1:0]  vld,
   output ll_entry_t [DEPTH-1:0]  ents
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr, rd_ptr, count;
   ll_entry_t [DEPTH-1:0] mem;
   logic do_push, do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];
   assign ents    = mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         vld    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         // push and pop never hit the same slot: that needs count 0 or DEPTH
         for (int i = 0; i < DEPTH; i++) begin
            if (do_pop && rd_ptr[AW-1:0] == AW'(i))  vld[i] <= 1'b0;
            if (do_push && wr_ptr[AW-1:0] == AW'(i)) vld[i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/rf_wr_port_arbiter.sv
// Shares the RF write port: writeback first, long-latency FIFO drains into idle cycles.
// Optional starvation guard enabled by defining RF_WR_STARVE_GUARD_EN.
module rf_wr_port_arbiter
   import rf_wr_port_arbiter_pkg::*;
#(
   parameter int DEPTH        = RF_LL_FIFO_DEPTH,
   parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb_wr_en_i,
   input  logic [4:0]  wb_wr_reg_i,
   input  logic [31:0] wb_wr_data_i,
   input  logic        ll_valid_i,
   output logic        ll_ready_o,
   input  logic [4:0]  ll_rd_i,
   input  logic [31:0] ll_data_i,
   output logic        rf_wr_en_o,
   output logic [4:0]  rf_wr_reg_o,
   output logic [31:0] rf_wr_data_o,
   output logic [31:0] pend_mask_o,
   output logic        stall_req_o
);

   logic                  push, pop, full, empty;
   ll_entry_t             din, head;
   logic      [DEPTH-1:0] vld;
   ll_entry_t [DEPTH-1:0] ents;
   rf_wr_req_t            wr;
   logic      [31:0]      mask;

   // x0 results complete the handshake but are never stored
   assign ll_ready_o = !full;
   assign push       = ll_valid_i && !full && (ll_rd_i != 5'd0);
   assign din        = '{rd: ll_rd_i, data: ll_data_i};

   rf_ll_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .full  (full),
      .empty (empty),
      .vld   (vld),
      .ents  (ents)
   );

   always_comb begin
      wr  = '0;
      pop = 1'b0;
      if (wb_wr_en_i) begin
         wr = '{en: 1'b1, wreg: wb_wr_reg_i, data: wb_wr_data_i};
      end else if (!empty) begin
         wr  = '{en: 1'b1, wreg: head.rd, data: head.data};
         pop = 1'b1;
      end
   end

   assign rf_wr_en_o   = wr.en;
   assign rf_wr_reg_o  = wr.wreg;
   assign rf_wr_data_o = wr.data;

   always_comb begin
      mask = '0;
      for (int i = 0; i < DEPTH; i++)
         if (vld[i]) mask = mask | rd_onehot(ents[i].rd);
   end

   assign pend_mask_o = {mask[31:1], 1'b0};

`ifdef RF_WR_STARVE_GUARD_EN
   logic [7:0] starve_cnt;
   logic       stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
         stall_q    <= 1'b0;
      end else begin
         stall_q <= 1'b0;
         if (pop || empty) begin
            starve_cnt <= '0;
         end else if (wb_wr_en_i) begin
            if (starve_cnt + 8'd1 == 8'(STARVE_LIMIT)) begin
               stall_q    <= 1'b1;
               starve_cnt <= '0;
            end else begin
               starve_cnt <= starve_cnt + 8'd1;
            end
         end
      end
   end

   assign stall_req_o = stall_q;
`else
   assign stall_req_o = 1'b0;
`endif

endmodule

// File: doc/rf_wr_port_arbiter.md
# rf_wr_port_arbiter

Shares the single register-file write port between the in-order writeback stage and the long-latency execution unit (multi-cycle divide/CSR-side results). Writeback always has priority. Long-latency results are accepted through a valid/ready handshake into a small FIFO and drain into idle write-port cycles. The block also exports a pending-destination mask so the hazard unit can block RAW/WAW on in-flight results. An optional starvation guard asks the pipeline for a bubble.

## Interface
Parameters:
- DEPTH, 2: long-latency result FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8: consecutive blocked cycles before the starvation guard fires; 1..255.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset; synchronous, active-high.
- wb_wr_en_i  in  1  writeback write request; already qualified by valid/squash/stall; cannot be back-pressured.
- wb_wr_reg_i  in  5  writeback destination.
- wb_wr_data_i  in  32  writeback data.
- ll_valid_i  in  1  long-latency result valid.
- ll_ready_o  out  1  FIFO can accept.
- ll_rd_i  in  5  long-latency destination.
- ll_data_i  in  32  long-latency data.
- rf_wr_en_o  out  1  register-file write enable.
- rf_wr_reg_o  out  5  register-file write address.
- rf_wr_data_o  out  32  register-file write data.
- pend_mask_o  out  32  bit r set while any FIFO entry targets xr; bit 0 always 0.
- stall_req_o  out  1  request to the hazard unit for one WB bubble.

## Operation
- FIFO: circular, read/write pointers of log2(DEPTH)+1 bits. count = wr_ptr − rd_ptr, modulo arithmetic. Full when count == DEPTH; empty when count == 0.
- Accept:
  - Push when ll_valid_i && ll_ready_o.
  - ll_ready_o = !full, registered state only; never depends on the same-cycle pop.
  - ll_rd_i == 0 is accepted and discarded: no push, and the handshake still completes.
- Port select, combinational:
  - If wb_wr_en_i: rf_wr_* = wb_*.
  - Else if FIFO non-empty: rf_wr_* = head entry, and the head pops this cycle.
  - Else rf_wr_en_o = 0, rf_wr_reg_o = 0, rf_wr_data_o = 0.
- Writes to x0: wb_wr_en_i with wb_wr_reg_i == 0 passes through unchanged. The register file ignores x0. The cycle is still treated as busy and the FIFO does not pop.
- pend_mask_o: OR of one-hot(rd) over valid entries, computed from registered FIFO state.
  - An entry pushed in cycle N is visible from N+1.
  - A popped entry clears from N+1.
- WAW/RAW ordering is the hazard unit's job via pend_mask_o. A WB write to a pending rd is not blocked here.
- Simultaneous push and pop at full: not possible, because ready is low. At any other count, push and pop together leave count unchanged.
- flush does not exist for this block. FIFO contents belong to committed instructions and are never discarded except by reset.

## Timing
- Reset values:
  - ll_ready_o = 1.
  - rf_wr_en_o = 0, rf_wr_reg_o = 0, rf_wr_data_o = 0.
  - pend_mask_o = 0.
  - stall_req_o = 0.
  - Pointers and starvation counter = 0.
- Latency: a result accepted in cycle N is written to the register file no earlier than N+1. It is written in N+1 if wb_wr_en_i is low then. There is no bypass from ll_* straight to rf_wr_*.
- Reset asserted mid-operation: all entries are dropped and outputs take reset values on the next edge. Any in-flight handshake in that cycle is lost.
- The writeback path is purely combinational: zero-cycle latency.

## Configuration
- RF_WR_STARVE_GUARD_EN defined:
  - An 8-bit counter increments each cycle the FIFO is non-empty and wb_wr_en_i is high.
  - It clears on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, stall_req_o is registered high for exactly one cycle and the counter clears.
  - The hazard unit then inserts one WB bubble, and the head drains.
- RF_WR_STARVE_GUARD_EN undefined: the counter is absent and stall_req_o is tied 0.

## Structure
- Shared package additions:
  - rf_wr_req_t {en, reg[4:0], data[31:0]}.
  - ll_entry_t {rd[4:0], data[31:0]}.
  - Default constants RF_LL_FIFO_DEPTH and RF_STARVE_LIMIT.
- One sub-module, rf_ll_fifo: a generic DEPTH-entry synchronous FIFO exposing the valid-entry vector used for the mask. Arbitration and the guard stay in the top.

## Test plan
- Post-reset idle: after rst_i is released, ll_ready_o = 1, rf_wr_en_o = 0, pend_mask_o = 0.
- Idle-port drain: push {rd=5, data=0xDEADBEEF} in cycle N with wb_wr_en_i = 0.
  - Cycle N+1: rf_wr_en_o = 1, rf_wr_reg_o = 5, rf_wr_data_o = 0xDEADBEEF.
  - pend_mask_o = 0x20 during N+1 only.
- Full back-pressure: hold wb_wr_en_i = 1 (rd=3).
  - Push rd=7 and rd=9 → ll_ready_o = 0, pend_mask_o = 0x280.
  - A third ll_valid_i is held off.
  - Drop wb_wr_en_i → rd 7 and rd 9 are written in order on consecutive cycles, and ready returns high.
- Simultaneous push/pop at count 1: count stays 1 and order is preserved (rd 7 is written before the new rd 12).
- x0 discard: push with ll_rd_i = 0 → handshake completes, pend_mask_o stays 0, and no register-file write occurs.
- Starvation guard (RF_WR_STARVE_GUARD_EN, STARVE_LIMIT = 8): one entry is pending and wb_wr_en_i is held high.
  - stall_req_o pulses exactly once, in the 9th cycle.
  - The entry drains on the first cycle wb_wr_en_i drops.
  - With the macro undefined, stall_req_o stays 0 throughout.
